// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, ALUOp codes,
// RV32I opcodes and the pc_sel / wd_sel / imm_sel selector values.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_e;

   localparam logic [4:0] ALU_NOP   = 5'd0;
   localparam logic [4:0] ALU_LUI   = 5'd1;
   localparam logic [4:0] ALU_AUIPC = 5'd2;
   localparam logic [4:0] ALU_ADD   = 5'd3;
   localparam logic [4:0] ALU_SUB   = 5'd4;
   localparam logic [4:0] ALU_BNE   = 5'd5;
   localparam logic [4:0] ALU_BLT   = 5'd6;
   localparam logic [4:0] ALU_BGE   = 5'd7;
   localparam logic [4:0] ALU_BLTU  = 5'd8;
   localparam logic [4:0] ALU_BGEU  = 5'd9;
   localparam logic [4:0] ALU_SLT   = 5'd10;
   localparam logic [4:0] ALU_SLTU  = 5'd11;
   localparam logic [4:0] ALU_XOR   = 5'd12;
   localparam logic [4:0] ALU_OR    = 5'd13;
   localparam logic [4:0] ALU_AND   = 5'd14;
   localparam logic [4:0] ALU_SLL   = 5'd15;
   localparam logic [4:0] ALU_SRL   = 5'd16;
   localparam logic [4:0] ALU_SRA   = 5'd17;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [1:0] PC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_IMM   = 2'd1;
   localparam logic [1:0] PC_ALU   = 2'd2;

   localparam logic [1:0] WD_ALU = 2'd0;
   localparam logic [1:0] WD_MEM = 2'd1;
   localparam logic [1:0] WD_PC4 = 2'd2;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// Combinational instruction-field decoder: maps (opcode, funct3, funct7)
// to ALUOp, immediate format, ALU B-operand select and a legality flag.
module mc_alu_dec
   import mc_ctrl_pkg::*;
#(
   parameter int IMM_SEL_W = 3
)(
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic [6:0]           funct7,
   output logic [4:0]           alu_op,
   output logic [IMM_SEL_W-1:0] imm_sel,
   output logic                 alu_src_b,
   output logic                 legal
);

   logic [2:0] imm_code_s;

   // decode table; anything not listed stays illegal
   always_comb begin
      alu_op     = ALU_NOP;
      imm_code_s = IMM_I;
      alu_src_b  = 1'b0;
      legal      = 1'b0;
      case (opcode)
         OPC_R: begin
            legal = 1'b1;
            case ({funct7, funct3})
               {F7_BASE, 3'b000}: alu_op = ALU_ADD;
               {F7_ALT,  3'b000}: alu_op = ALU_SUB;
               {F7_BASE, 3'b001}: alu_op = ALU_SLL;
               {F7_BASE, 3'b010}: alu_op = ALU_SLT;
               {F7_BASE, 3'b011}: alu_op = ALU_SLTU;
               {F7_BASE, 3'b100}: alu_op = ALU_XOR;
               {F7_BASE, 3'b101}: alu_op = ALU_SRL;
               {F7_ALT,  3'b101}: alu_op = ALU_SRA;
               {F7_BASE, 3'b110}: alu_op = ALU_OR;
               {F7_BASE, 3'b111}: alu_op = ALU_AND;
               default:           legal  = 1'b0;
            endcase
         end
         OPC_IMM: begin
            legal     = 1'b1;
            alu_src_b = 1'b1;
            case (funct3)
               3'b000: alu_op = ALU_ADD;
               3'b010: alu_op = ALU_SLT;
               3'b011: alu_op = ALU_SLTU;
               3'b100: alu_op = ALU_XOR;
               3'b110: alu_op = ALU_OR;
               3'b111: alu_op = ALU_AND;
               3'b001: begin
                  alu_op = ALU_SLL;
                  if (funct7 == F7_BASE) legal = 1'b1;
                  else                   legal = 1'b0;
               end
               3'b101: begin
                  if (funct7 == F7_BASE)     alu_op = ALU_SRL;
                  else if (funct7 == F7_ALT) alu_op = ALU_SRA;
                  else                       legal  = 1'b0;
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            legal     = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
         end
         OPC_STORE: begin
            alu_op     = ALU_ADD;
            alu_src_b  = 1'b1;
            imm_code_s = IMM_S;
            legal      = (funct3 <= 3'b010);
         end
         OPC_BRANCH: begin
            imm_code_s = IMM_B;
            legal      = 1'b1;
            case (funct3)
               3'b000:  alu_op = ALU_SUB;
               3'b001:  alu_op = ALU_BNE;
               3'b100:  alu_op = ALU_BLT;
               3'b101:  alu_op = ALU_BGE;
               3'b110:  alu_op = ALU_BLTU;
               3'b111:  alu_op = ALU_BGEU;
               default: legal  = 1'b0;
            endcase
         end
         OPC_LUI: begin
            alu_op     = ALU_LUI;
            alu_src_b  = 1'b1;
            imm_code_s = IMM_U;
            legal      = 1'b1;
         end
         OPC_AUIPC: begin
            alu_op     = ALU_AUIPC;
            alu_src_b  = 1'b1;
            imm_code_s = IMM_U;
            legal      = 1'b1;
         end
         OPC_JAL: begin
            imm_code_s = IMM_J;
            legal      = 1'b1;
         end
         OPC_JALR: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            legal     = (funct3 == 3'b000);
         end
         default: legal = 1'b0;
      endcase
   end

   assign imm_sel = IMM_SEL_W'(imm_code_s);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, runs the
// imem/dmem req/ack handshakes and drives the datapath enables and selects.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int IMM_SEL_W = 3
)(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [31:0]          instr,
   input  logic                 imem_ack,
   input  logic                 dmem_ack,
   input  logic                 Zero,
   output logic                 imem_req,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic [1:0]           pc_sel,
   output logic                 rf_we,
   output logic [1:0]           wd_sel,
   output logic                 alu_src_b,
   output logic [4:0]           alu_op,
   output logic [IMM_SEL_W-1:0] imm_sel,
   output logic                 illegal,
   output logic [2:0]           state
);

   state_e                 state_r, state_next_s;
   logic [6:0]             opcode_r;
   logic [2:0]             funct3_r;
   logic [6:0]             funct7_r;
   logic [4:0]             dec_alu_op_s;
   logic [IMM_SEL_W-1:0]   dec_imm_sel_s;
   logic                   dec_src_b_s;
   logic                   dec_legal_s;
   logic                   is_load_s, is_store_s, is_branch_s, is_jal_s, is_jalr_s;
   logic                   unused_s;

   mc_alu_dec #(.IMM_SEL_W(IMM_SEL_W)) u_dec (
      .opcode    (opcode_r),
      .funct3    (funct3_r),
      .funct7    (funct7_r),
      .alu_op    (dec_alu_op_s),
      .imm_sel   (dec_imm_sel_s),
      .alu_src_b (dec_src_b_s),
      .legal     (dec_legal_s)
   );

   assign is_load_s   = (opcode_r == OPC_LOAD);
   assign is_store_s  = (opcode_r == OPC_STORE);
   assign is_branch_s = (opcode_r == OPC_BRANCH);
   assign is_jal_s    = (opcode_r == OPC_JAL);
   assign is_jalr_s   = (opcode_r == OPC_JALR);
   assign unused_s    = ^{instr[24:15], instr[11:7]};
   assign state       = state_r;

   // state register and instruction-field latch (loaded only on the fetch ack)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r  <= ST_IDLE;
         opcode_r <= 7'd0;
         funct3_r <= 3'd0;
         funct7_r <= 7'd0;
      end else begin
         state_r <= state_next_s;
         if (ir_we) begin
            opcode_r <= instr[6:0];
            funct3_r <= instr[14:12];
            funct7_r <= instr[31:25];
         end
      end
   end

   // next state and outputs; ALU controls stay driven from EXEC through WB
   // so the ALU result is still valid when it is written back
   always_comb begin
      state_next_s = state_r;
      imem_req     = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_PLUS4;
      rf_we        = 1'b0;
      wd_sel       = WD_ALU;
      alu_src_b    = 1'b0;
      alu_op       = ALU_NOP;
      imm_sel      = {IMM_SEL_W{1'b0}};
      illegal      = 1'b0;
      case (state_r)
         ST_IDLE: state_next_s = ST_FETCH;
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_we        = 1'b1;
               state_next_s = ST_DECODE;
            end else begin
               state_next_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (dec_legal_s) state_next_s = ST_EXEC;
            else             state_next_s = ST_TRAP;
         end
         ST_EXEC: begin
            alu_op    = dec_alu_op_s;
            alu_src_b = dec_src_b_s;
            imm_sel   = dec_imm_sel_s;
            if (is_branch_s) begin
               pc_we        = 1'b1;
               pc_sel       = Zero ? PC_IMM : PC_PLUS4;
               state_next_s = ST_FETCH;
            end else if (is_load_s || is_store_s) begin
               state_next_s = ST_MEM;
            end else begin
               state_next_s = ST_WB;
            end
         end
         ST_MEM: begin
            alu_op    = dec_alu_op_s;
            alu_src_b = dec_src_b_s;
            imm_sel   = dec_imm_sel_s;
            dmem_req  = 1'b1;
            dmem_we   = is_store_s;
            if (dmem_ack && is_store_s) begin
               pc_we        = 1'b1;
               state_next_s = ST_FETCH;
            end else if (dmem_ack) begin
               state_next_s = ST_WB;
            end else begin
               state_next_s = ST_MEM;
            end
         end
         ST_WB: begin
            alu_op       = dec_alu_op_s;
            alu_src_b    = dec_src_b_s;
            imm_sel      = dec_imm_sel_s;
            rf_we        = 1'b1;
            pc_we        = 1'b1;
            state_next_s = ST_FETCH;
            if (is_load_s) begin
               wd_sel = WD_MEM;
            end else if (is_jal_s) begin
               wd_sel = WD_PC4;
               pc_sel = PC_IMM;
            end else if (is_jalr_s) begin
               wd_sel = WD_PC4;
               pc_sel = PC_ALU;
            end else begin
               wd_sel = WD_ALU;
            end
         end
         ST_TRAP: begin
            illegal      = 1'b1;
            state_next_s = ST_TRAP;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

endmodule
